// File: rtl/l2_instr_mem_responder_if.sv
// Bus bundle for the L2 instruction responder: L1 line-fill request/response channels,
// backing SRAM read port and the busy status.
interface l2_instr_mem_responder_if #(
    parameter int LINE_WIDTH = 512,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8
);
    logic                    req_valid_i;
    logic                    req_rw_i;
    logic [LINE_WIDTH/8-1:0] req_byteen_i;
    logic [ADDR_WIDTH-1:0]   req_addr_i;
    logic [LINE_WIDTH-1:0]   req_data_i;
    logic [TAG_WIDTH-1:0]    req_tag_i;
    logic                    req_ready_o;

    logic                    rsp_valid_o;
    logic [LINE_WIDTH-1:0]   rsp_data_o;
    logic [TAG_WIDTH-1:0]    rsp_tag_o;
    logic                    rsp_ready_i;

    logic                    sram_req_o;
    logic [ADDR_WIDTH-1:0]   sram_addr_o;
    logic [LINE_WIDTH-1:0]   sram_rdata_i;

    logic                    busy_o;

    modport slave (
        input  req_valid_i, req_rw_i, req_byteen_i, req_addr_i, req_data_i, req_tag_i,
        input  rsp_ready_i, sram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o,
        output sram_req_o, sram_addr_o, busy_o
    );

    modport master (
        output req_valid_i, req_rw_i, req_byteen_i, req_addr_i, req_data_i, req_tag_i,
        output rsp_ready_i, sram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o,
        input  sram_req_o, sram_addr_o, busy_o
    );
endinterface

// File: rtl/l2_instr_mem_responder.sv
// Read-only line-fill responder: credit-gated SRAM reads, tag pipeline and in-order response FIFO.
// Build macro INSTR_MEM_RSP_STATS_EN adds the rd_count_o / wr_drop_count_o statistics outputs.
module l2_instr_mem_responder #(
    parameter int LINE_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    l2_instr_mem_responder_if.slave bus
`ifdef INSTR_MEM_RSP_STATS_EN
    ,
    output logic [31:0] rd_count_o,
    output logic [15:0] wr_drop_count_o
`endif
);
    localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("l2_instr_mem_responder: RD_LATENCY must be in 1..4");
    end
    if (RSP_FIFO_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
        $error("l2_instr_mem_responder: RSP_FIFO_DEPTH must be >= RD_LATENCY+1");
    end

    logic [CNT_W-1:0]      cnt;
    logic                  ready;
    logic                  accept;
    logic                  accept_rd;
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [TAG_WIDTH-1:0]  pipe_tag [RD_LATENCY];
    logic                  push;
    logic                  pop;
    logic                  rsp_vld;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [LINE_WIDTH-1:0] data_mem [RSP_FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem  [RSP_FIFO_DEPTH];
    logic                  unused_inputs;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // cnt counts every read from acceptance until its response pops, so the FIFO cannot overflow.
    assign ready     = !rst_i && (cnt < CNT_W'(RSP_FIFO_DEPTH));
    assign accept    = bus.req_valid_i && ready;
    assign accept_rd = accept && !bus.req_rw_i;
    assign push      = pipe_vld[RD_LATENCY-1];
    assign rsp_vld   = (fifo_cnt != '0);
    assign pop       = rsp_vld && bus.rsp_ready_i;

    assign bus.req_ready_o = ready;
    assign bus.sram_req_o  = accept_rd;
    assign bus.sram_addr_o = bus.req_addr_i;
    assign bus.rsp_valid_o = rsp_vld;
    assign bus.rsp_data_o  = rsp_vld ? data_mem[rd_ptr] : '0;
    assign bus.rsp_tag_o   = rsp_vld ? tag_mem[rd_ptr]  : '0;
    assign bus.busy_o      = (cnt != '0);
    assign unused_inputs   = ^{bus.req_byteen_i, bus.req_data_i};

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept_rd;
            pipe_tag[0] <= bus.req_tag_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            cnt      <= cnt + CNT_W'(accept_rd) - CNT_W'(pop);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // NOTE: line storage is not reset; outputs are masked to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr] <= bus.sram_rdata_i;
            tag_mem[wr_ptr]  <= pipe_tag[RD_LATENCY-1];
        end
    end

`ifdef INSTR_MEM_RSP_STATS_EN
    logic accept_wr;
    assign accept_wr = accept && bus.req_rw_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_count_o      <= '0;
            wr_drop_count_o <= '0;
        end else begin
            if (accept_rd) begin
                rd_count_o <= rd_count_o + 32'd1;
            end
            if (accept_wr && (wr_drop_count_o != 16'hFFFF)) begin
                wr_drop_count_o <= wr_drop_count_o + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_l2_instr_mem_responder.sv
// Self-checking bench for l2_instr_mem_responder: scenario tasks plus a queue-based response model.
// Build with INSTR_MEM_RSP_STATS_EN defined to also cover the statistics counters.
module tb_l2_instr_mem_responder;
    localparam int LINE_WIDTH     = 512;
    localparam int ADDR_WIDTH     = 26;
    localparam int TAG_WIDTH      = 8;
    localparam int RD_LATENCY     = 1;
    localparam int RSP_FIFO_DEPTH = 4;
    localparam int WORDS          = LINE_WIDTH / 32;
`ifdef INSTR_MEM_RSP_STATS_EN
    localparam int WR_BURST = 70000;
`else
    localparam int WR_BURST = 50;
`endif

    logic clk = 1'b0;
    logic rst;

    l2_instr_mem_responder_if #(
        .LINE_WIDTH(LINE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH)
    ) bus ();

`ifdef INSTR_MEM_RSP_STATS_EN
    logic [31:0] rd_count;
    logic [15:0] wr_drop_count;
`endif

    l2_instr_mem_responder #(
        .LINE_WIDTH(LINE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH),
        .RD_LATENCY(RD_LATENCY), .RSP_FIFO_DEPTH(RSP_FIFO_DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
`ifdef INSTR_MEM_RSP_STATS_EN
        ,
        .rd_count_o(rd_count),
        .wr_drop_count_o(wr_drop_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Backing store contents are a fixed function of the line address.
    function automatic logic [LINE_WIDTH-1:0] line_of(input logic [ADDR_WIDTH-1:0] a);
        logic [LINE_WIDTH-1:0] r;
        for (int w = 0; w < WORDS; w++) begin
            r[w*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(w) * 32'h01000193) ^ 32'h5A5A0000;
        end
        return r;
    endfunction

    // SRAM model: data appears RD_LATENCY cycles after a strobe, random junk otherwise.
    logic [RD_LATENCY-1:0] sram_v = '0;
    logic [ADDR_WIDTH-1:0] sram_a [RD_LATENCY];
    logic [LINE_WIDTH-1:0] junk = '0;

    always @(posedge clk) begin
        sram_v[0] <= bus.sram_req_o;
        sram_a[0] <= bus.sram_addr_o;
        for (int i = 1; i < RD_LATENCY; i++) begin
            sram_v[i] <= sram_v[i-1];
            sram_a[i] <= sram_a[i-1];
        end
        for (int w = 0; w < WORDS; w++) begin
            junk[w*32 +: 32] <= $urandom;
        end
    end

    assign bus.sram_rdata_i = sram_v[RD_LATENCY-1] ? line_of(sram_a[RD_LATENCY-1]) : junk;

    // Reference model: every accepted read owes one response, available RD_LATENCY+1 cycles later.
    typedef struct {
        logic [TAG_WIDTH-1:0]  tag;
        logic [LINE_WIDTH-1:0] data;
        int                    avail;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    logic [31:0] m_rd = '0;
    logic [15:0] m_wr = '0;

    logic                  obs_ready, obs_valid, obs_sram_req, obs_busy;
    logic [TAG_WIDTH-1:0]  obs_tag;
    logic [LINE_WIDTH-1:0] obs_data;

    // One clock: compare outputs to the model at the falling edge, then advance the model.
    task automatic cycle();
        logic                  exp_ready, exp_valid, acc, rd, wr, do_pop;
        logic [TAG_WIDTH-1:0]  c_tag;
        logic [ADDR_WIDTH-1:0] c_addr;
        exp_t                  e;
        @(negedge clk);
        exp_ready = (exp_q.size() < RSP_FIFO_DEPTH);
        exp_valid = (exp_q.size() != 0) && (exp_q[0].avail <= cyc);
        acc       = bus.req_valid_i && exp_ready;
        rd        = acc && !bus.req_rw_i;
        wr        = acc && bus.req_rw_i;
        do_pop    = exp_valid && bus.rsp_ready_i;
        c_tag     = bus.req_tag_i;
        c_addr    = bus.req_addr_i;

        obs_ready    = bus.req_ready_o;
        obs_valid    = bus.rsp_valid_o;
        obs_sram_req = bus.sram_req_o;
        obs_busy     = bus.busy_o;
        obs_tag      = bus.rsp_tag_o;
        obs_data     = bus.rsp_data_o;

        checks++;
        if (obs_ready !== exp_ready) begin
            errors++;
            $display("FAIL req_ready cyc=%0d: got %b want %b", cyc, obs_ready, exp_ready);
        end
        checks++;
        if (obs_valid !== exp_valid) begin
            errors++;
            $display("FAIL rsp_valid cyc=%0d: got %b want %b", cyc, obs_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (obs_tag !== exp_q[0].tag) begin
                errors++;
                $display("FAIL rsp_tag cyc=%0d: got %h want %h", cyc, obs_tag, exp_q[0].tag);
            end
            checks++;
            if (obs_data !== exp_q[0].data) begin
                errors++;
                $display("FAIL rsp_data cyc=%0d: got %h want %h", cyc, obs_data, exp_q[0].data);
            end
        end
        checks++;
        if (obs_sram_req !== rd) begin
            errors++;
            $display("FAIL sram_req cyc=%0d: got %b want %b", cyc, obs_sram_req, rd);
        end
        if (rd) begin
            checks++;
            if (bus.sram_addr_o !== c_addr) begin
                errors++;
                $display("FAIL sram_addr cyc=%0d: got %h want %h", cyc, bus.sram_addr_o, c_addr);
            end
        end
        checks++;
        if (obs_busy !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL busy cyc=%0d: got %b want %b", cyc, obs_busy, exp_q.size() != 0);
        end
`ifdef INSTR_MEM_RSP_STATS_EN
        checks++;
        if (rd_count !== m_rd) begin
            errors++;
            $display("FAIL rd_count cyc=%0d: got %0d want %0d", cyc, rd_count, m_rd);
        end
        checks++;
        if (wr_drop_count !== m_wr) begin
            errors++;
            $display("FAIL wr_drop_count cyc=%0d: got %0d want %0d", cyc, wr_drop_count, m_wr);
        end
`endif
        @(posedge clk);
        if (do_pop) void'(exp_q.pop_front());
        if (rd) begin
            e.tag   = c_tag;
            e.data  = line_of(c_addr);
            e.avail = cyc + RD_LATENCY + 1;
            exp_q.push_back(e);
            m_rd = m_rd + 32'd1;
        end
        if (wr && m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rd = '0;
        m_wr = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < 64) begin
            cycle();
            n++;
        end
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid_i  = 1'b1;
        bus.req_rw_i     = 1'b0;
        bus.req_addr_i   = 26'h123;
        bus.req_tag_i    = 8'h11;
        bus.req_byteen_i = '1;
        bus.req_data_i   = '0;
        bus.rsp_ready_i  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #3;
            checks++;
            if (bus.req_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || bus.sram_req_o !== 1'b0 ||
                bus.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl: got ready=%b valid=%b sram_req=%b busy=%b want all 0",
                         bus.req_ready_o, bus.rsp_valid_o, bus.sram_req_o, bus.busy_o);
            end
            checks++;
            if (bus.rsp_tag_o !== '0 || bus.rsp_data_o !== '0) begin
                errors++;
                $display("FAIL reset_rsp: got tag=%h data=%h want 0", bus.rsp_tag_o, bus.rsp_data_o);
            end
            repeat (2) @(posedge clk);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid_i = 1'b0;
        model_reset();
        cycle();
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", obs_ready);
        end
    endtask

    task automatic test_single_read();
        int lat;
        bus.req_valid_i = 1'b1;
        bus.req_rw_i    = 1'b0;
        bus.req_addr_i  = 26'h10;
        bus.req_tag_i   = 8'h3A;
        bus.rsp_ready_i = 1'b1;
        cycle();
        checks++;
        if (obs_sram_req !== 1'b1) begin
            errors++;
            $display("FAIL single_sram_req: got %b want 1", obs_sram_req);
        end
        bus.req_valid_i = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            lat++;
            if (obs_valid === 1'b1) break;
        end
        checks++;
        if (lat != RD_LATENCY + 1 || obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got %0d (valid=%b) want %0d", lat, obs_valid, RD_LATENCY + 1);
        end
        checks++;
        if (obs_tag !== 8'h3A || obs_data !== line_of(26'h10)) begin
            errors++;
            $display("FAIL single_rsp: got tag %h want 3a", obs_tag);
        end
        cycle();
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_after_pop: got %b want 0", obs_busy);
        end
    endtask

    task automatic test_back_to_back();
        int tags_seen[$];
        int first, last, ready_low;
        first = -1; last = -1; ready_low = 0;
        bus.rsp_ready_i = 1'b1;
        bus.req_rw_i    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.req_valid_i = (i < 8);
            bus.req_addr_i  = ADDR_WIDTH'($urandom);
            bus.req_tag_i   = TAG_WIDTH'(i);
            cycle();
            if (i < 8 && obs_ready !== 1'b1) ready_low++;
            if (obs_valid === 1'b1) begin
                tags_seen.push_back(int'(obs_tag));
                if (first < 0) first = i;
                last = i;
            end
        end
        checks++;
        if (ready_low != 0) begin
            errors++;
            $display("FAIL b2b_ready: got %0d low cycles want 0", ready_low);
        end
        checks++;
        if (tags_seen.size() != 8 || last - first != 7) begin
            errors++;
            $display("FAIL b2b_burst: got %0d rsps over %0d cycles want 8 over 8",
                     tags_seen.size(), last - first + 1);
        end
        for (int k = 0; k < tags_seen.size() && k < 8; k++) begin
            checks++;
            if (tags_seen[k] != k) begin
                errors++;
                $display("FAIL b2b_order[%0d]: got %0d want %0d", k, tags_seen[k], k);
            end
        end
    endtask

    task automatic test_backpressure();
        int accepted;
        logic stalled;
        logic [TAG_WIDTH-1:0]  held_tag;
        logic [LINE_WIDTH-1:0] held_data;
        accepted = 0; stalled = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.req_rw_i    = 1'b0;
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < 20 && !stalled; i++) begin
            bus.req_addr_i = ADDR_WIDTH'($urandom);
            bus.req_tag_i  = TAG_WIDTH'(8'h80 + i);
            cycle();
            if (obs_ready === 1'b1) accepted++;
            else stalled = 1'b1;
        end
        bus.req_valid_i = 1'b0;
        checks++;
        if (!stalled || accepted != RSP_FIFO_DEPTH) begin
            errors++;
            $display("FAIL bp_accepted: got %0d (stalled=%b) want %0d", accepted, stalled, RSP_FIFO_DEPTH);
        end
        held_tag  = obs_tag;
        held_data = obs_data;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (obs_valid !== 1'b1 || obs_tag !== held_tag || obs_data !== held_data) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b tag=%h want valid=1 tag=%h", obs_valid, obs_tag, held_tag);
            end
        end
        bus.rsp_ready_i = 1'b1;
        cycle();
        checks++;
        if (obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_in_pop_cycle: got %b want 0", obs_ready);
        end
        cycle();
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after_pop: got %b want 1", obs_ready);
        end
        drain();
    endtask

    task automatic test_write_drop();
        int seen;
        seen = 0;
        bus.rsp_ready_i = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_rw_i    = 1'b1;
        bus.req_addr_i  = 26'h77;
        bus.req_tag_i   = 8'h55;
        cycle();
        checks++;
        if (obs_ready !== 1'b1 || obs_sram_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_accept: got ready=%b sram_req=%b want 1/0", obs_ready, obs_sram_req);
        end
        bus.req_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (obs_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL wr_no_rsp: got %0d responses want 0", seen);
        end
`ifdef INSTR_MEM_RSP_STATS_EN
        checks++;
        if (wr_drop_count !== 16'd1) begin
            errors++;
            $display("FAIL wr_drop_count_one: got %0d want 1", wr_drop_count);
        end
`endif
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < WR_BURST; i++) begin
            bus.req_addr_i = ADDR_WIDTH'($urandom);
            bus.req_tag_i  = TAG_WIDTH'($urandom);
            cycle();
        end
        bus.req_valid_i = 1'b0;
        bus.req_rw_i    = 1'b0;
        cycle();
`ifdef INSTR_MEM_RSP_STATS_EN
        checks++;
        if (wr_drop_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wr_drop_count_sat: got %h want ffff", wr_drop_count);
        end
`endif
    endtask

    task automatic test_simultaneous();
        int more;
        more = 0;
        bus.rsp_ready_i = 1'b0;
        bus.req_rw_i    = 1'b0;
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr_i = ADDR_WIDTH'($urandom);
            bus.req_tag_i  = TAG_WIDTH'(8'hC0 + i);
            cycle();
        end
        bus.req_valid_i = 1'b0;
        repeat (RD_LATENCY + 1) cycle();
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = ADDR_WIDTH'($urandom);
        bus.req_tag_i   = 8'hC3;
        bus.rsp_ready_i = 1'b1;
        cycle();
        checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL sim_accept_pop: got ready=%b valid=%b want 1/1", obs_ready, obs_valid);
        end
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.req_addr_i = ADDR_WIDTH'($urandom);
            bus.req_tag_i  = TAG_WIDTH'(8'hD0 + i);
            cycle();
            if (obs_ready !== 1'b1) break;
            more++;
        end
        checks++;
        if (more != 1) begin
            errors++;
            $display("FAIL sim_credits_left: got %0d more accepts want 1", more);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.req_valid_i  = ($urandom_range(1, 0) == 1);
            bus.req_rw_i     = ($urandom_range(3, 0) == 0);
            bus.req_addr_i   = ADDR_WIDTH'($urandom);
            bus.req_tag_i    = TAG_WIDTH'($urandom);
            bus.req_byteen_i = {$urandom, $urandom};
            for (int w = 0; w < WORDS; w++) bus.req_data_i[w*32 +: 32] = $urandom;
            bus.rsp_ready_i  = ($urandom_range(9, 0) < 7);
            cycle();
        end
        drain();
    endtask

    task automatic test_midop_reset();
        int stale;
        logic got;
        stale = 0; got = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.req_rw_i    = 1'b0;
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.req_addr_i = ADDR_WIDTH'($urandom);
            bus.req_tag_i  = TAG_WIDTH'(8'hE0 + i);
            cycle();
        end
        bus.req_valid_i = 1'b0;
        cycle();
        checks++;
        if (obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_valid: got %b want 1", obs_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_immediate: got valid=%b busy=%b ready=%b want 0/0/0",
                     bus.rsp_valid_o, bus.busy_o, bus.req_ready_o);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (obs_valid === 1'b1) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midrst_stale: got %0d responses want 0", stale);
        end
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 26'h2AB;
        bus.req_tag_i   = 8'h01;
        cycle();
        bus.req_valid_i = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle();
            if (obs_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || obs_tag !== 8'h01 || obs_data !== line_of(26'h2AB)) begin
            errors++;
            $display("FAIL midrst_next_read: got valid=%b tag=%h want 1/01", got, obs_tag);
        end
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_backpressure();
        test_write_drop();
        test_simultaneous();
        test_random();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l2_instr_mem_responder.md
Name: l2_instr_mem_responder

Overview:
- Memory-side responder for the L1 instruction cache's line-fill port.
- Accepts line requests from the L1 mem_req channel and reads full lines from a fixed-latency backing SRAM port.
- Returns data with the original tag on the mem_rsp channel, in order, with credit-based buffering so backpressure never loses data.
- Read-only path: write requests are accepted and dropped.

Parameters:
LINE_WIDTH, 512, cache line width in bits (64 B line)
ADDR_WIDTH, 26, line address width
TAG_WIDTH, 8, request tag width
RD_LATENCY, 1, SRAM read latency in cycles (1..4)
RSP_FIFO_DEPTH, 4, response buffer entries; must be >= RD_LATENCY+1 (elaboration error otherwise)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  1  request valid
req_rw_i  in  1  1 = write (dropped), 0 = read
req_byteen_i  in  LINE_WIDTH/8  byte enables (ignored)
req_addr_i  in  ADDR_WIDTH  line address
req_data_i  in  LINE_WIDTH  write data (ignored)
req_tag_i  in  TAG_WIDTH  request tag
req_ready_o  out  1  request accepted when valid&&ready
rsp_valid_o  out  1  response valid
rsp_data_o  out  LINE_WIDTH  line data
rsp_tag_o  out  TAG_WIDTH  tag of the corresponding read
rsp_ready_i  in  1  consumer ready
sram_req_o  out  1  SRAM read strobe
sram_addr_o  out  ADDR_WIDTH  SRAM line address
sram_rdata_i  in  LINE_WIDTH  SRAM data, valid RD_LATENCY cycles after strobe
busy_o  out  1  any read in flight or buffered

Behaviour:
- Reset (rst_i=1, async):
  - Clears the credit counter, tag pipeline valid bits and FIFO pointers.
  - While asserted: req_ready_o=0, rsp_valid_o=0, sram_req_o=0, busy_o=0; rsp_data_o/rsp_tag_o=0.
  - First cycle after release: req_ready_o=1.
- Credit counter `cnt` (width clog2(RSP_FIFO_DEPTH+1)) = reads in SRAM pipeline + FIFO occupancy.
  - req_ready_o = (cnt < RSP_FIFO_DEPTH), registered-state only, no combinational path from req_valid_i.
- Accepted read in cycle T:
  - sram_req_o=1 and sram_addr_o=req_addr_i combinationally in T.
  - Tag enters an RD_LATENCY-stage valid/tag shift pipeline.
  - cnt increments.
- Stage RD_LATENCY output valid: sram_rdata_i and the tag are written into the FIFO at the end of cycle T+RD_LATENCY.
  - rsp_valid_o rises in cycle T+RD_LATENCY+1.
  - Minimum latency is therefore RD_LATENCY+1.
- Response pop (rsp_valid_o && rsp_ready_i): FIFO head advances, cnt decrements.
  - Accept and pop in the same cycle: cnt unchanged.
  - Write into an empty FIFO and pop in the same cycle are never concurrent, since the head is registered.
- Response hold: rsp_data_o/rsp_tag_o are stable while rsp_valid_o && !rsp_ready_i.
- Ordering: responses return strictly in request order.
- Throughput: 1 line/cycle sustained with rsp_ready_i=1.
- Full: cnt==RSP_FIFO_DEPTH forces req_ready_o=0; the FIFO can never overflow because credits cover in-flight reads.
- FIFO pointers wrap modulo RSP_FIFO_DEPTH; non-power-of-2 depth is supported by explicit compare-and-wrap.
- Accepted write (req_rw_i=1):
  - Consumes no credit, issues no SRAM access, produces no response.
  - req_ready_o is still gated by cnt.
- busy_o = (cnt != 0).
- Reset mid-operation: in-flight and buffered reads are discarded; no response is emitted for them.
- Elaboration error if RD_LATENCY is outside 1..4.

Optional Feature:
- Macro: INSTR_MEM_RSP_STATS_EN.
- When defined, adds two outputs, both cleared by rst_i:
  - rd_count_o [31:0]: accepted reads, wraps at 2^32.
  - wr_drop_count_o [15:0]: accepted writes, saturates at 16'hFFFF.
- When undefined, both ports and their counters are absent and writes are dropped silently.
- Core datapath timing is identical in both builds.

Test Plan:
- Single read: reset, addr=0x10, tag=0x3A, SRAM returns line L, RD_LATENCY=1 -> sram_req_o in T, rsp_valid_o in T+2 with data=L, tag=0x3A; busy_o falls after pop.
- Back-to-back: 8 reads, tags 0..7, rsp_ready_i=1 -> 8 consecutive rsp_valid_o cycles, tags 0..7 in order, req_ready_o never low.
- Backpressure: rsp_ready_i=0, issue reads until stall -> exactly 4 accepted, then req_ready_o=0.
  - Head data/tag held stable.
  - Release rsp_ready_i: 4 in-order responses, req_ready_o=1 the cycle after the first pop.
- Write drop: rw=1, tag=0x55 -> accepted, sram_req_o=0, no response; with INSTR_MEM_RSP_STATS_EN, wr_drop_count_o=1.
  - 70000 writes -> wr_drop_count_o=0xFFFF.
- Simultaneous: FIFO at 3 entries, accept read while popping -> cnt stays 3, new response lands in order.
- Mid-op reset: 2 reads in flight, pulse rst_i -> rsp_valid_o=0 immediately, no stale response after release, next read tag 0x01 returned correctly.
